stage_two: RTL and testbench
============================

Name: stage_two

Overview:
Execute stage of the 3-stage CPU pipeline. It is the consumer of stage one's flopped outputs: it applies the final stage-three forwarding and performs the ALU operation. A sequential signed divider lives here and back-pressures stage one through stage_stall. It drives the stage-two forwarding/hazard signals (aluout, s2_instruction, s2_R0_en) back to stage one and flops results into the stage-three (memory/writeback) register.

Parameters:
DATA_W, 16, operand width; results are 2*DATA_W.
DIV_CYCLES, 16, divider iterations; must equal DATA_W.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
halt_sys  in  1  main-control halt; freezes all state
in_memc  in  2  memory control from stage one
in_reg_wr  in  1  register write enable from stage one
in_alu  in  32  in_t operand pair {b[31:16], a[15:0]}
in_R1_data  in  16  store data / R1 value
in_haz1  in  1  forward s3_data[15:0] onto operand a
in_haz2  in  1  forward s3_data[15:0] onto operand b
in_R0_en  in  1  instruction writes upper half to R0
in_alu_ctrl  in  4  control_e ALU operation
in_instr  in  8  top 8 instruction bits {opcode, r1}
s3_data  in  32  stage-three writeback data for forwarding
aluout  out  32  combinational ALU result (stage-one forwarding)
s2_instruction  out  8  equals in_instr (combinational)
s2_R0_en  out  1  equals in_R0_en (combinational)
stage_stall  out  1  divider busy; stage one must hold
out_memc  out  2  flopped to stage three
out_reg_wr  out  1  flopped
out_result  out  32  flopped ALU result
out_R1_data  out  16  flopped
out_R0_en  out  1  flopped
out_instr  out  8  flopped
out_div0  out  1  flopped divide-by-zero flag
out_overflow  out  1  flopped signed overflow flag

Behaviour:
- Reset: every out_* is 0, divider FSM is IDLE, count is 0, stage_stall is 0. Reset asserted mid-divide aborts the divide with no result.
- Operand a = in_haz1 ? s3_data[15:0] : in_alu.a. Operand b = in_haz2 ? s3_data[15:0] : in_alu.b.
- Single-cycle ops:
  - ADD/SUB: 16-bit two's complement; upper result half = 0; overflow set on signed overflow.
  - AND, OR: bitwise; upper half = 0.
  - SLL/SRL/ROL/ROR: shift or rotate by b[3:0]; upper half = 0.
  - MUL: signed 16x16 product; low half to [15:0], high half to [31:16].
- Pipeline register:
  - halt_sys=1: hold all flops and the FSM.
  - stage_stall=1: load a bubble (out_reg_wr=0, out_memc=0, out_R0_en=0; others 0).
  - Otherwise capture the inputs and the result (1-cycle latency).
- DIV FSM states: IDLE, BUSY.
  - IDLE, DIV presented, b!=0: latch |a|, |b| and the sign bits, clear count, go BUSY. stage_stall=1 this cycle.
  - IDLE, DIV, b==0: no FSM entry; result 0, div0=1, single cycle.
  - BUSY: one restoring-division step per cycle, count++. stage_stall=1 while count<DIV_CYCLES-1.
  - BUSY, count==DIV_CYCLES-1: final step; stage_stall=0, the flop captures the result, return to IDLE.
  - stage_stall is high for 16 consecutive cycles; the result reaches out_result on the 17th edge after the DIV arrives.
  - Result: quotient in [15:0], remainder in [31:16]. Quotient is negative if the signs differ; remainder takes the dividend's sign.
  - -32768 / -1: quotient 0x8000, remainder 0, overflow=1.
- aluout during BUSY shows the latched partial state. Stage one must not consume it; the hazard unit stalls on busy.
- halt_sys during BUSY freezes count and the partial remainder; the divide resumes when halt_sys deasserts.

Decomposition:
- cpu_pkg holds: control_e encoding (ADD, SUB, AND, OR, SLL, SRL, ROL, ROR, MUL, DIV), opcode_t, in_t struct {a, b}, DIV_CYCLES constant.
- Sub-module alu_divider_seq holds the FSM, count, and the remainder/quotient shift registers.
  - Ports: clk, rst, hold, start, dividend, divisor, busy, done, quotient, remainder, overflow.
  - stage_two instantiates it and contains the combinational ALU and the pipeline flop.

Test Plan:
- Reset mid-BUSY at count 7 -> all out_* 0, stage_stall 0; the next ADD 3+4 gives out_result 0x0000_0007 one edge later.
- ADD 0x7FFF+0x0001 -> out_result[15:0]=0x8000, out_overflow=1, 1-cycle latency. SUB 5-9 -> 0xFFFC, overflow 0.
- MUL -3 * 1000 -> out_result=0xFFFF_F448 with out_R0_en passed through. in_haz1=1, s3_data=0x0000_0002, a=9, ADD b=1 -> result 3.
- DIV -7 / 2:
  - stage_stall high exactly 16 cycles.
  - During the stall, out_reg_wr is a bubble (0).
  - The result then shows out_result[15:0]=0xFFFD and [31:16]=0xFFFF.
- DIV by 0 -> no stall, out_result 0, out_div0=1. DIV 0x8000 / 0xFFFF -> out_result[15:0]=0x8000, out_overflow=1.
- halt_sys pulsed for 3 cycles mid-DIV -> stage_stall length extends by 3 and the quotient is still correct: 100/7 gives 14 with remainder 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 3-stage CPU pipeline.
// ALU control encoding, operand bundle and divider constants.
package cpu_pkg;

   localparam int XLEN       = 16;
   localparam int DIV_CYCLES = 16;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLL = 4'd4,
      ALU_SRL = 4'd5,
      ALU_ROL = 4'd6,
      ALU_ROR = 4'd7,
      ALU_MUL = 4'd8,
      ALU_DIV = 4'd9
   } control_e;

   typedef logic [3:0] opcode_t;

   typedef struct packed {
      opcode_t    opcode;
      logic [3:0] r1;
   } instr_hi_t;

   typedef struct packed {
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] a;
   } in_t;

   typedef enum logic {
      DIV_IDLE,
      DIV_BUSY
   } div_state_e;

endpackage

// File: rtl/stage_two_divider.sv
// Sequential signed restoring divider, one quotient bit per cycle.
// The last step is combinational so the result is ready as busy drops.
module alu_divider_seq #(
   parameter int W = 16,
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         overflow
);
   import cpu_pkg::*;

   localparam int CW = $clog2(N);

   div_state_e    state_q;
   logic [CW-1:0] count_q;
   logic [W-1:0]  rem_q;
   logic [W-1:0]  quo_q;
   logic [W-1:0]  dvs_q;
   logic          sa_q;
   logic          sb_q;
   logic          ovf_q;

   logic [W:0]    trial;
   logic [W-1:0]  diff;
   logic          fits;
   logic [W-1:0]  rem_d;
   logic [W-1:0]  quo_d;
   logic [W-1:0]  a_mag;
   logic [W-1:0]  b_mag;
   logic          last;

   always_comb begin
      trial = {rem_q, quo_q[W-1]};
      diff  = trial[W-1:0] - dvs_q;
      fits  = trial >= {1'b0, dvs_q};
      rem_d = fits ? diff : trial[W-1:0];
      quo_d = {quo_q[W-2:0], fits};
   end

   assign a_mag = dividend[W-1] ? -dividend : dividend;
   assign b_mag = divisor[W-1]  ? -divisor  : divisor;
   assign last  = (state_q == DIV_BUSY) && (count_q == CW'(N-1));

   // Busy covers the launch cycle so stage one holds from the first edge.
   assign busy = !rst && ((state_q == DIV_IDLE) ? start : !last);
   assign done = last;

   assign quotient  = (sa_q ^ sb_q) ? -quo_d : quo_d;
   assign remainder = sa_q ? -rem_d : rem_d;
   assign overflow  = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         count_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (!hold) begin
         unique case (state_q)
            DIV_IDLE: begin
               if (start) begin
                  rem_q   <= '0;
                  quo_q   <= a_mag;
                  dvs_q   <= b_mag;
                  sa_q    <= dividend[W-1];
                  sb_q    <= divisor[W-1];
                  ovf_q   <= (dividend == {1'b1, {(W-1){1'b0}}})
                             && (&divisor);
                  count_q <= '0;
                  state_q <= DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               rem_q   <= rem_d;
               quo_q   <= quo_d;
               count_q <= count_q + 1'b1;
               if (last) begin
                  state_q <= DIV_IDLE;
               end
            end
            default: state_q <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/stage_two.sv
// Execute stage: forwarding muxes, ALU, divider and the
// register feeding the memory/writeback stage.
module stage_two #(
   parameter int DATA_W     = cpu_pkg::XLEN,
   parameter int DIV_CYCLES = cpu_pkg::DIV_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                halt_sys,
   input  logic [1:0]          in_memc,
   input  logic                in_reg_wr,
   input  cpu_pkg::in_t        in_alu,
   input  logic [DATA_W-1:0]   in_R1_data,
   input  logic                in_haz1,
   input  logic                in_haz2,
   input  logic                in_R0_en,
   input  logic [3:0]          in_alu_ctrl,
   input  logic [7:0]          in_instr,
   input  logic [2*DATA_W-1:0] s3_data,
   output logic [2*DATA_W-1:0] aluout,
   output logic [7:0]          s2_instruction,
   output logic                s2_R0_en,
   output logic                stage_stall,
   output logic [1:0]          out_memc,
   output logic                out_reg_wr,
   output logic [2*DATA_W-1:0] out_result,
   output logic [DATA_W-1:0]   out_R1_data,
   output logic                out_R0_en,
   output logic [7:0]          out_instr,
   output logic                out_div0,
   output logic                out_overflow
);
   import cpu_pkg::*;

   localparam int SH_W = $clog2(DATA_W);
   localparam int MSB  = DATA_W - 1;

   control_e                   ctrl;
   logic [DATA_W-1:0]          op_a;
   logic [DATA_W-1:0]          op_b;
   logic [DATA_W-1:0]          sum;
   logic [DATA_W-1:0]          dif;
   logic [2*DATA_W-1:0]        rol_w;
   logic [2*DATA_W-1:0]        ror_w;
   logic signed [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0]        res;
   logic                       ovf;
   logic                       div0;

   logic                       dv_start;
   logic                       dv_busy;
   logic                       dv_done;
   logic                       dv_ovf;
   logic [DATA_W-1:0]          dv_q;
   logic [DATA_W-1:0]          dv_r;

   logic [1:0]                 memc_q;
   logic                       reg_wr_q;
   logic [2*DATA_W-1:0]        result_q;
   logic [DATA_W-1:0]          r1_q;
   logic                       r0_en_q;
   instr_hi_t                  instr_q;
   logic                       div0_q;
   logic                       ovf_q;
   logic                       unused;

   assign ctrl = control_e'(in_alu_ctrl);
   assign op_a = in_haz1 ? s3_data[DATA_W-1:0] : in_alu.a;
   assign op_b = in_haz2 ? s3_data[DATA_W-1:0] : in_alu.b;

   assign sum   = op_a + op_b;
   assign dif   = op_a - op_b;
   assign rol_w = {op_a, op_a} << op_b[SH_W-1:0];
   assign ror_w = {op_a, op_a} >> op_b[SH_W-1:0];
   assign prod  = $signed(op_a) * $signed(op_b);

   assign dv_start = (ctrl == ALU_DIV) && (op_b != '0);

   alu_divider_seq #(
      .W (DATA_W),
      .N (DIV_CYCLES)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .hold      (halt_sys),
      .start     (dv_start),
      .dividend  (op_a),
      .divisor   (op_b),
      .busy      (dv_busy),
      .done      (dv_done),
      .quotient  (dv_q),
      .remainder (dv_r),
      .overflow  (dv_ovf)
   );

   always_comb begin
      res  = '0;
      ovf  = 1'b0;
      div0 = 1'b0;
      unique case (ctrl)
         ALU_ADD: begin
            res[MSB:0] = sum;
            ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
         end
         ALU_SUB: begin
            res[MSB:0] = dif;
            ovf = (op_a[MSB] != op_b[MSB]) && (dif[MSB] != op_a[MSB]);
         end
         ALU_AND: res[MSB:0] = op_a & op_b;
         ALU_OR:  res[MSB:0] = op_a | op_b;
         ALU_SLL: res[MSB:0] = op_a << op_b[SH_W-1:0];
         ALU_SRL: res[MSB:0] = op_a >> op_b[SH_W-1:0];
         ALU_ROL: res[MSB:0] = rol_w[2*DATA_W-1:DATA_W];
         ALU_ROR: res[MSB:0] = ror_w[MSB:0];
         ALU_MUL: res = prod;
         ALU_DIV: begin
            if (op_b == '0) begin
               div0 = 1'b1;
            end else begin
               res = {dv_r, dv_q};
               ovf = dv_ovf;
            end
         end
         default: res = '0;
      endcase
   end

   assign aluout         = res;
   assign s2_instruction = in_instr;
   assign s2_R0_en       = in_R0_en;
   assign stage_stall    = dv_busy;

   // A stalled cycle loads a bubble; halt freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memc_q   <= '0;
         reg_wr_q <= 1'b0;
         result_q <= '0;
         r1_q     <= '0;
         r0_en_q  <= 1'b0;
         instr_q  <= '0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (!halt_sys) begin
         if (stage_stall) begin
            memc_q   <= '0;
            reg_wr_q <= 1'b0;
            result_q <= '0;
            r1_q     <= '0;
            r0_en_q  <= 1'b0;
            instr_q  <= '0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
         end else begin
            memc_q   <= in_memc;
            reg_wr_q <= in_reg_wr;
            result_q <= res;
            r1_q     <= in_R1_data;
            r0_en_q  <= in_R0_en;
            instr_q  <= in_instr;
            div0_q   <= div0;
            ovf_q    <= ovf;
         end
      end
   end

   assign out_memc     = memc_q;
   assign out_reg_wr   = reg_wr_q;
   assign out_result   = result_q;
   assign out_R1_data  = r1_q;
   assign out_R0_en    = r0_en_q;
   assign out_instr    = instr_q;
   assign out_div0     = div0_q;
   assign out_overflow = ovf_q;

   assign unused = ^{s3_data[2*DATA_W-1:DATA_W], dv_done};

endmodule

// File: tb/tb_stage_two.sv
// Scoreboard bench for stage_two: stimulus pushes expectations,
// a monitor pops them whenever a real instruction leaves the stage.
module tb_stage_two;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt_sys = 1'b0;
   logic [1:0]  in_memc = '0;
   logic        in_reg_wr = 1'b0;
   logic [31:0] in_alu = '0;
   logic [15:0] in_R1_data = '0;
   logic        in_haz1 = 1'b0;
   logic        in_haz2 = 1'b0;
   logic        in_R0_en = 1'b0;
   logic [3:0]  in_alu_ctrl = '0;
   logic [7:0]  in_instr = '0;
   logic [31:0] s3_data = '0;
   logic [31:0] aluout;
   logic [7:0]  s2_instruction;
   logic        s2_R0_en;
   logic        stage_stall;
   logic [1:0]  out_memc;
   logic        out_reg_wr;
   logic [31:0] out_result;
   logic [15:0] out_R1_data;
   logic        out_R0_en;
   logic [7:0]  out_instr;
   logic        out_div0;
   logic        out_overflow;

   stage_two dut (
      .clk            (clk),
      .rst            (rst),
      .halt_sys       (halt_sys),
      .in_memc        (in_memc),
      .in_reg_wr      (in_reg_wr),
      .in_alu         (in_alu),
      .in_R1_data     (in_R1_data),
      .in_haz1        (in_haz1),
      .in_haz2        (in_haz2),
      .in_R0_en       (in_R0_en),
      .in_alu_ctrl    (in_alu_ctrl),
      .in_instr       (in_instr),
      .s3_data        (s3_data),
      .aluout         (aluout),
      .s2_instruction (s2_instruction),
      .s2_R0_en       (s2_R0_en),
      .stage_stall    (stage_stall),
      .out_memc       (out_memc),
      .out_reg_wr     (out_reg_wr),
      .out_result     (out_result),
      .out_R1_data    (out_R1_data),
      .out_R0_en      (out_R0_en),
      .out_instr      (out_instr),
      .out_div0       (out_div0),
      .out_overflow   (out_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic        div0;
      logic        ovf;
      logic        r0;
      logic [7:0]  instr;
      logic [1:0]  memc;
      logic [15:0] r1;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   // Reference: signed integer arithmetic straight from the op rules.
   function automatic logic [33:0] ref_alu(input int op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
      int sa, sb, ua, sh, s, q, r;
      logic [31:0] t, res;
      logic ov, d0;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      sh = b[3:0];
      res = '0;
      ov = 1'b0;
      d0 = 1'b0;
      case (op)
         0: begin
            s = sa + sb; t = s; res = {16'h0, t[15:0]};
            ov = (s > 32767) || (s < -32768);
         end
         1: begin
            s = sa - sb; t = s; res = {16'h0, t[15:0]};
            ov = (s > 32767) || (s < -32768);
         end
         2: res = {16'h0, a & b};
         3: res = {16'h0, a | b};
         4: begin t = (ua << sh) & 32'hFFFF; res = t; end
         5: begin t = ua >> sh; res = t; end
         6: begin t = ((ua << sh) | (ua >> (16 - sh))) & 32'hFFFF; res = t; end
         7: begin t = ((ua >> sh) | (ua << (16 - sh))) & 32'hFFFF; res = t; end
         8: begin s = sa * sb; res = s; end
         default: begin
            if (b == 16'h0) begin
               d0 = 1'b1;
            end else if (sa == -32768 && sb == -1) begin
               res = 32'h0000_8000;
               ov = 1'b1;
            end else begin
               q = sa / sb;
               r = sa % sb;
               t = q;
               res[15:0] = t[15:0];
               t = r;
               res[31:16] = t[15:0];
            end
         end
      endcase
      return {d0, ov, res};
   endfunction

   // Called and returns at a falling edge; hs>=0 pulses halt 3 cycles.
   task automatic issue(input int op, input logic [15:0] a,
                        input logic [15:0] b, input logic h1,
                        input logic h2, input logic [31:0] s3,
                        input logic r0, input int hs, input string nm);
      logic [15:0] ea, eb;
      logic [33:0] m;
      exp_t e;
      int c, stall_n, want;
      in_alu_ctrl = op[3:0];
      in_alu = {b, a};
      in_haz1 = h1;
      in_haz2 = h2;
      s3_data = s3;
      in_R0_en = r0;
      in_reg_wr = 1'b1;
      in_memc = 2'($urandom_range(0, 3));
      in_R1_data = 16'($urandom);
      in_instr = 8'($urandom);
      ea = h1 ? s3[15:0] : a;
      eb = h2 ? s3[15:0] : b;
      m = ref_alu(op, ea, eb);
      e.res = m[31:0];
      e.ovf = m[32];
      e.div0 = m[33];
      e.r0 = r0;
      e.instr = in_instr;
      e.memc = in_memc;
      e.r1 = in_R1_data;
      exp_q.push_back(e);
      want = (op == 9 && eb != 16'h0) ? 16 : 0;
      if (want != 0 && hs >= 0) want += 3;
      c = 0;
      stall_n = 0;
      forever begin
         halt_sys = (hs >= 0) && (c >= hs) && (c < hs + 3);
         #1;
         if (stage_stall) stall_n++;
         if (!stage_stall && !halt_sys) break;
         @(negedge clk);
         c++;
         if (c > 200) begin
            $display("FAIL %s: stall timeout got %0d cycles", nm, c);
            checks++;
            halt_sys = 1'b0;
            break;
         end
      end
      chk({nm, " stall"}, 64'(stall_n), 64'(want));
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: a capture happened at an edge where halt and reset were low.
   initial begin
      logic hw;
      exp_t e, act;
      forever begin
         @(posedge clk);
         hw = halt_sys || rst;
         @(negedge clk);
         if (!hw && out_reg_wr) begin
            act = {out_result, out_div0, out_overflow, out_R0_en,
                   out_instr, out_memc, out_R1_data};
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected: got %h required none", act);
            end else begin
               e = exp_q.pop_front();
               chk("result", 64'(act), 64'(e));
            end
         end
      end
   end

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h8000;
         1: return 16'hFFFF;
         2: return 16'h0000;
         3: return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      logic [15:0] a, b;
      repeat (2) @(negedge clk);
      #1;
      chk("reset outs", {out_result, out_R1_data, out_instr, out_memc,
          out_reg_wr, out_R0_en, out_div0, out_overflow}, 64'h0);
      chk("reset stall", 64'(stage_stall), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      in_alu_ctrl = 4'd9;
      in_alu = {16'd3, 16'd50};
      in_reg_wr = 1'b1;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst outs", {out_result, out_R1_data, out_instr, out_memc,
          out_reg_wr, out_R0_en, out_div0, out_overflow}, 64'h0);
      chk("midrst stall", 64'(stage_stall), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      issue(0, 16'd3, 16'd4, 0, 0, 0, 0, -1, "add 3+4");

      issue(0, 16'h7FFF, 16'h0001, 0, 0, 0, 0, -1, "add ovf");
      issue(1, 16'd5, 16'd9, 0, 0, 0, 0, -1, "sub");
      issue(8, 16'hFFFD, 16'd1000, 0, 0, 0, 1, -1, "mul");
      issue(0, 16'd9, 16'd1, 1, 0, 32'h2, 0, -1, "haz1 add");
      issue(9, 16'hFFF9, 16'd2, 0, 0, 0, 0, -1, "div -7/2");
      issue(9, 16'd77, 16'd0, 0, 0, 0, 0, -1, "div0");
      issue(9, 16'h8000, 16'hFFFF, 0, 0, 0, 0, -1, "div ovf");
      issue(9, 16'd100, 16'd7, 0, 0, 0, 0, 5, "div halt");
      issue(6, 16'h8001, 16'd0, 0, 0, 0, 0, -1, "rol 0");
      issue(7, 16'h0001, 16'd1, 0, 0, 0, 0, -1, "ror 1");

      for (int i = 0; i < 250; i++) begin
         a = pick();
         b = pick();
         issue($urandom_range(0, 9), a, b, 1'($urandom),
               1'($urandom), $urandom, 1'($urandom), -1, "rand");
      end

      in_reg_wr = 1'b0;
      repeat (4) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
